// File: rtl/v_pkg.sv
// Shared types for the list-engine update path: command payload fields,
// the bundled update record and the ingress sequencer states.
package v_pkg;

   localparam int ID_W   = 8;
   localparam int KEY_W  = 16;
   localparam int SIZE_W = 16;

   typedef logic [ID_W-1:0]   id_t;
   typedef logic [KEY_W-1:0]  key_t;
   typedef logic [SIZE_W-1:0] size_t;

   typedef enum logic [1:0] {
      CMD_ADD = 2'd0,
      CMD_MOD = 2'd1,
      CMD_DEL = 2'd2,
      CMD_CLR = 2'd3
   } cmd_t;

   typedef struct packed {
      id_t   prod_id;
      cmd_t  cmd;
      key_t  key;
      size_t size;
   } upd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } ingress_state_t;

endpackage

// File: rtl/v_upd_fifo.sv
// Register FIFO of update records with push/pop/flush; occupancy is kept as a
// separate counter one bit wider than the pointers so full and empty are exact.
module v_upd_fifo
   import v_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  upd_t                     din,
   output upd_t                     dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   upd_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Flush dominates both operations so a cleared FIFO never sees a stray entry.
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (level == LVL_W'(DEPTH));
   assign empty = (level == '0);

endmodule

// File: rtl/v_upd_ingress.sv
// Ingress buffer in front of the list engine update bus: queues producer
// commands and issues them as single-cycle registered pulses, throttled by busy.
module v_upd_ingress
   import v_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int HOLDOFF = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_in_vld,
   input  id_t                     i_in_prod_id,
   input  cmd_t                    i_in_cmd,
   input  key_t                    i_in_key,
   input  size_t                   i_in_size,
   output logic                    o_in_rdy,
   input  logic                    i_flush,
   input  logic                    i_busy_r,
   output logic                    o_upd_vld_r,
   output id_t                     o_upd_prod_id_r,
   output cmd_t                    o_upd_cmd_r,
   output key_t                    o_upd_key_r,
   output size_t                   o_upd_size_r,
   output logic [$clog2(DEPTH):0]  o_level_r,
   output logic [31:0]             o_issued_r,
   output ingress_state_t          o_state_r
);

   // Handshake: a command transfers on a rising clk edge where i_in_vld and
   // o_in_rdy are both high; o_in_rdy never looks at a same-cycle pop.
   localparam int HOLD_EFF = (HOLDOFF < 1) ? 1 : HOLDOFF;
   localparam int CNT_W    = $clog2(HOLD_EFF + 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   ingress_state_t   state_r, state_nxt;
   logic [CNT_W-1:0] cnt_r, cnt_nxt;
   logic             vld_nxt;
   upd_t             upd_r, upd_nxt;
   logic [31:0]      issued_nxt;
   upd_t             in_upd;
   upd_t             head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;

   assign in_upd   = '{prod_id: i_in_prod_id, cmd: i_in_cmd, key: i_in_key, size: i_in_size};
   assign o_in_rdy = rst & ~fifo_full & ~i_flush;
   assign push     = i_in_vld & o_in_rdy;

   v_upd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (i_flush),
      .din   (in_upd),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (o_level_r)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         o_upd_vld_r <= 1'b0;
         upd_r       <= '0;
         o_issued_r  <= '0;
      end else begin
         state_r     <= state_nxt;
         cnt_r       <= cnt_nxt;
         o_upd_vld_r <= vld_nxt;
         upd_r       <= upd_nxt;
         o_issued_r  <= issued_nxt;
      end
   end

   // The head is popped on the edge that enters ISSUE, so the ISSUE cycle is
   // exactly the cycle o_upd_vld_r is high; cnt then counts the holdoff window.
   always_comb begin
      state_nxt  = state_r;
      cnt_nxt    = cnt_r;
      vld_nxt    = 1'b0;
      upd_nxt    = upd_r;
      issued_nxt = o_issued_r;
      pop        = 1'b0;
      case (state_r)
         IDLE: begin
            if (!fifo_empty && !i_busy_r && !i_flush) begin
               pop        = 1'b1;
               state_nxt  = ISSUE;
               vld_nxt    = 1'b1;
               upd_nxt    = head;
               cnt_nxt    = HOLD_LOAD;
               issued_nxt = o_issued_r + 32'd1;
            end
         end
         ISSUE, HOLD: begin
            if (cnt_r <= CNT_ONE) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               state_nxt = HOLD;
               cnt_nxt   = cnt_r - CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign o_upd_prod_id_r = upd_r.prod_id;
   assign o_upd_cmd_r     = upd_r.cmd;
   assign o_upd_key_r     = upd_r.key;
   assign o_upd_size_r    = upd_r.size;
   assign o_state_r       = state_r;

endmodule

// File: tb/tb_v_upd_ingress.sv
// Bench for v_upd_ingress: a queue/timestamp model checked every cycle, plus
// directed scenarios with literal expectations on pulse timing and order.
module tb_v_upd_ingress;
   import v_pkg::*;

   localparam int DEPTH    = 8;
   localparam int HOLDOFF  = 2;
   localparam int HOLD_EFF = (HOLDOFF < 1) ? 1 : HOLDOFF;
   localparam int LW       = $clog2(DEPTH) + 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_vld = 1'b0;
   id_t            in_prod_id = '0;
   cmd_t           in_cmd = CMD_ADD;
   key_t           in_key = '0;
   size_t          in_size = '0;
   logic           in_rdy;
   logic           flush = 1'b0;
   logic           busy = 1'b0;
   logic           upd_vld;
   id_t            upd_prod_id;
   cmd_t           upd_cmd;
   key_t           upd_key;
   size_t          upd_size;
   logic [LW-1:0]  level;
   logic [31:0]    issued;
   ingress_state_t state;

   int     tests_run = 0;
   int     tests_failed = 0;
   longint cyc = 0;

   v_upd_ingress #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
      .clk             (clk),
      .rst             (rst_n),
      .i_in_vld        (in_vld),
      .i_in_prod_id    (in_prod_id),
      .i_in_cmd        (in_cmd),
      .i_in_key        (in_key),
      .i_in_size       (in_size),
      .o_in_rdy        (in_rdy),
      .i_flush         (flush),
      .i_busy_r        (busy),
      .o_upd_vld_r     (upd_vld),
      .o_upd_prod_id_r (upd_prod_id),
      .o_upd_cmd_r     (upd_cmd),
      .o_upd_key_r     (upd_key),
      .o_upd_size_r    (upd_size),
      .o_level_r       (level),
      .o_issued_r      (issued),
      .o_state_r       (state)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a queue of accepted commands plus the edge of the last issue.
   // An issue happens on an edge when something was queued before it, busy and
   // flush are low, and at least HOLD_EFF+1 edges have passed since the last one.
   logic [$bits(upd_t)-1:0] exp_q[$];
   logic        m_vld;
   upd_t        m_upd;
   logic [31:0] m_issued;
   longint      m_edge, m_last;

   initial begin
      bit   m_rdy, m_iss;
      upd_t in_rec;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            exp_q.delete();
            m_vld    = 1'b0;
            m_upd    = '0;
            m_issued = '0;
            m_edge   = 0;
            m_last   = -1000;
         end else begin
            m_edge++;
            in_rec = '{prod_id: in_prod_id, cmd: in_cmd, key: in_key, size: in_size};
            m_rdy  = (exp_q.size() < DEPTH) && !flush;
            m_iss  = (exp_q.size() != 0) && !busy && !flush && (m_edge - m_last >= HOLD_EFF + 1);
            m_vld  = m_iss;
            if (m_iss) begin
               m_upd = upd_t'(exp_q.pop_front());
               m_issued++;
               m_last = m_edge;
            end
            if (flush) exp_q.delete();
            if (in_vld && m_rdy) exp_q.push_back(in_rec);
         end
      end
   end

   // scoreboard compare on every falling edge, plus a log of observed pulses
   longint p_cyc[$];
   upd_t   p_upd[$];

   initial begin
      forever begin
         @(negedge clk);
         chk("cmp_vld",    64'(upd_vld), 64'(m_vld));
         chk("cmp_payload", 64'({upd_prod_id, upd_cmd, upd_key, upd_size}), 64'(m_upd));
         chk("cmp_level",  64'(level), 64'(exp_q.size()));
         chk("cmp_issued", 64'(issued), 64'(m_issued));
         chk("cmp_rdy",    64'(in_rdy), 64'(rst_n && (exp_q.size() < DEPTH) && !flush));
         if (upd_vld) begin
            p_cyc.push_back(cyc);
            p_upd.push_back('{prod_id: upd_prod_id, cmd: upd_cmd, key: upd_key, size: upd_size});
         end
      end
   end

   // driver tasks: all driving happens 2ns after a rising edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push(input id_t id, input cmd_t c, input key_t k, input size_t s, output longint pc);
      logic r;
      in_vld = 1'b1; in_prod_id = id; in_cmd = c; in_key = k; in_size = s;
      pc = -1;
      for (int i = 0; i < 300; i++) begin
         #1;
         r = in_rdy;
         @(posedge clk);
         #2;
         if (r) begin
            pc = cyc;
            break;
         end
      end
      in_vld = 1'b0;
      if (pc < 0) chk("push_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint pc, pc0, c;
      int     n0;

      // reset
      repeat (3) @(posedge clk);
      #2;
      chk("rst_rdy",    64'(in_rdy), 64'd0);
      chk("rst_vld",    64'(upd_vld), 64'd0);
      chk("rst_level",  64'(level), 64'd0);
      chk("rst_issued", 64'(issued), 64'd0);
      rst_n = 1'b1;
      tick(2);

      // single command: pulse the edge after the push edge
      n0 = p_cyc.size();
      push(8'd3, CMD_ADD, 16'h0010, 16'd5, pc);
      chk("t1_level_push", 64'(level), 64'd1);
      tick(1);
      chk("t1_vld",    64'(upd_vld), 64'd1);
      chk("t1_id",     64'(upd_prod_id), 64'd3);
      chk("t1_key",    64'(upd_key), 64'h10);
      chk("t1_size",   64'(upd_size), 64'd5);
      chk("t1_issued", 64'(issued), 64'd1);
      chk("t1_level",  64'(level), 64'd0);
      tick(4);
      chk("t1_npulse", 64'(p_cyc.size() - n0), 64'd1);

      // four back-to-back pushes: pulses three cycles apart, in order
      n0 = p_cyc.size();
      push(8'd1, CMD_ADD, 16'h0021, 16'd1, pc0);
      for (int i = 1; i < 4; i++) push(8'd1, CMD_MOD, key_t'(16'h0021 + i), size_t'(i + 1), pc);
      tick(15);
      chk("t2_npulse", 64'(p_cyc.size() - n0), 64'd4);
      if (p_cyc.size() >= n0 + 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("t2_time", 64'(p_cyc[n0+i]), 64'(pc0 + 1 + 3*i));
            chk("t2_key",  64'(p_upd[n0+i].key), 64'(16'h0021 + i));
         end
      end

      // fill while busy; ninth command stalls and is not lost
      busy = 1'b1;
      tick(1);
      n0 = p_cyc.size();
      for (int i = 0; i < 8; i++) push(8'd2, CMD_ADD, key_t'(16'h0030 + i), size_t'(i), pc);
      chk("t3_level_full", 64'(level), 64'd8);
      chk("t3_rdy_full",   64'(in_rdy), 64'd0);
      in_vld = 1'b1; in_key = 16'h0038;
      tick(4);
      chk("t3_level_stall", 64'(level), 64'd8);
      chk("t3_no_pulse",    64'(p_cyc.size() - n0), 64'd0);
      busy = 1'b0;
      push(8'd2, CMD_DEL, 16'h0038, 16'd8, pc);
      tick(40);
      chk("t3_npulse", 64'(p_cyc.size() - n0), 64'd9);
      if (p_cyc.size() >= n0 + 9)
         for (int i = 0; i < 9; i++) chk("t3_order", 64'(p_upd[n0+i].key), 64'(16'h0030 + i));

      // busy held for 20 cycles with two queued
      busy = 1'b1;
      push(8'd4, CMD_ADD, 16'h0041, 16'd1, pc);
      push(8'd4, CMD_ADD, 16'h0042, 16'd2, pc);
      n0 = p_cyc.size();
      tick(20);
      chk("t4_no_pulse", 64'(p_cyc.size() - n0), 64'd0);
      busy = 1'b0;
      c = cyc;
      tick(10);
      chk("t4_npulse", 64'(p_cyc.size() - n0), 64'd2);
      if (p_cyc.size() >= n0 + 2) begin
         chk("t4_first_time", 64'(p_cyc[n0]), 64'(c + 1));
         chk("t4_first_key",  64'(p_upd[n0].key), 64'h41);
         chk("t4_second_time", 64'(p_cyc[n0+1]), 64'(c + 4));
      end

      // flush with level 5 and a concurrent push
      busy = 1'b1;
      for (int i = 0; i < 5; i++) push(8'd5, CMD_MOD, key_t'(16'h0050 + i), 16'd9, pc);
      chk("t5_level5", 64'(level), 64'd5);
      flush = 1'b1; in_vld = 1'b1; in_key = 16'h005F;
      #1;
      chk("t5_rdy_flush", 64'(in_rdy), 64'd0);
      @(posedge clk);
      #2;
      flush = 1'b0; in_vld = 1'b0;
      chk("t5_level0", 64'(level), 64'd0);
      busy = 1'b0;
      n0 = p_cyc.size();
      tick(10);
      chk("t5_no_pulse", 64'(p_cyc.size() - n0), 64'd0);
      chk("t5_issued",   64'(issued), 64'd16);

      // async reset mid-HOLD with three still queued
      busy = 1'b1;
      for (int i = 0; i < 4; i++) push(8'd6, CMD_ADD, key_t'(16'h0060 + i), 16'd3, pc);
      busy = 1'b0;
      tick(2);
      chk("t6_state_hold", 64'(state), 64'(HOLD));
      chk("t6_level3",     64'(level), 64'd3);
      #4;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_vld",    64'(upd_vld), 64'd0);
      chk("t6_rst_level",  64'(level), 64'd0);
      chk("t6_rst_issued", 64'(issued), 64'd0);
      chk("t6_rst_key",    64'(upd_key), 64'd0);
      chk("t6_rst_rdy",    64'(in_rdy), 64'd0);
      @(posedge clk);
      #2;
      tick(1);
      rst_n = 1'b1;
      n0 = p_cyc.size();
      tick(10);
      chk("t6_no_pulse", 64'(p_cyc.size() - n0), 64'd0);
      push(8'd7, CMD_CLR, 16'h0070, 16'd1, pc);
      tick(3);
      chk("t6_npulse", 64'(p_cyc.size() - n0), 64'd1);
      if (p_cyc.size() >= n0 + 1) chk("t6_time", 64'(p_cyc[n0]), 64'(pc + 1));
      chk("t6_issued", 64'(issued), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
